// File: rtl/miner_pkg.sv
// Shared types for the hash responder: controller state encoding and default widths.
package miner_pkg;

  localparam int NONCE_W_DEF  = 32;
  localparam int DIGEST_W_DEF = 256;

  typedef logic [NONCE_W_DEF-1:0]  nonce_t;
  typedef logic [DIGEST_W_DEF-1:0] digest_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/nonce_counter.sv
// Free-running nonce counter with a sticky wrap flag.
// A synchronous clear has priority over increment.
module nonce_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
      if (&count_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/hash_responder.sv
// Mining attempt controller: snapshots the nonce, drives the hash core and compares its digest
// against the target. Optional watchdog on the core wait is enabled by HASH_RESPONDER_WATCHDOG_EN.
module hash_responder
  import miner_pkg::*;
#(
  parameter int NONCE_W     = NONCE_W_DEF,
  parameter int DIGEST_W    = DIGEST_W_DEF,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loadTarget,
  input  logic [DIGEST_W-1:0] target_in,
  input  logic                reset,
  input  logic                beginSHA,
  input  logic                increment,
  output logic                sha_start,
  output logic [NONCE_W-1:0]  sha_nonce,
  input  logic                sha_done,
  input  logic [DIGEST_W-1:0] sha_digest,
  output logic                complete,
  output logic                valid,
  output logic                overflow,
  output logic [NONCE_W-1:0]  nonce,
  output logic                timeout
);

  state_e              state_q;
  logic                sha_start_q;
  logic [NONCE_W-1:0]  sha_nonce_q;
  logic [DIGEST_W-1:0] digest_q;
  logic [DIGEST_W-1:0] target_q;
  logic                valid_q;
  logic                complete_q;

`ifdef HASH_RESPONDER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;
`endif

  nonce_counter #(.W(NONCE_W)) u_nonce (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (reset),
    .inc_i      (increment),
    .count_o    (nonce),
    .overflow_o (overflow)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sha_start_q <= 1'b0;
      sha_nonce_q <= '0;
      digest_q    <= '0;
      target_q    <= '0;
      valid_q     <= 1'b0;
      complete_q  <= 1'b0;
`ifdef HASH_RESPONDER_WATCHDOG_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      // The compare in CMP reads target_q before this write lands, so a same-cycle load is deferred.
      if (loadTarget) target_q <= target_in;

      sha_start_q <= 1'b0;
      complete_q  <= 1'b0;

      if (reset) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
`ifdef HASH_RESPONDER_WATCHDOG_EN
        timeout_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (beginSHA) begin
              state_q     <= START;
              sha_start_q <= 1'b1;
              sha_nonce_q <= nonce;
              valid_q     <= 1'b0;
`ifdef HASH_RESPONDER_WATCHDOG_EN
              timeout_q   <= 1'b0;
`endif
            end
          end
          START: begin
            state_q <= WAIT;
`ifdef HASH_RESPONDER_WATCHDOG_EN
            wd_cnt_q <= '0;
`endif
          end
          WAIT: begin
            if (sha_done) begin
              digest_q <= sha_digest;
              state_q  <= CMP;
            end
`ifdef HASH_RESPONDER_WATCHDOG_EN
            else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
              state_q    <= DONE;
              complete_q <= 1'b1;
              valid_q    <= 1'b0;
              timeout_q  <= 1'b1;
            end else begin
              wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
`endif
          end
          CMP: begin
            valid_q    <= (digest_q < target_q);
            complete_q <= 1'b1;
            state_q    <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sha_start = sha_start_q;
  assign sha_nonce = sha_nonce_q;
  assign complete  = complete_q;
  assign valid     = valid_q;
`ifdef HASH_RESPONDER_WATCHDOG_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_hash_responder.sv
// Directed bench for hash_responder; watchdog steps follow HASH_RESPONDER_WATCHDOG_EN.
module tb_hash_responder;

  localparam int NW = 8;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          loadTarget;
  logic [DW-1:0] target_in;
  logic          reset;
  logic          beginSHA;
  logic          increment;
  logic          sha_start;
  logic [NW-1:0] sha_nonce;
  logic          sha_done;
  logic [DW-1:0] sha_digest;
  logic          complete;
  logic          valid;
  logic          overflow;
  logic [NW-1:0] nonce;
  logic          timeout;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] tgt;

  hash_responder #(.NONCE_W(NW), .DIGEST_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .loadTarget (loadTarget),
    .target_in  (target_in),
    .reset      (reset),
    .beginSHA   (beginSHA),
    .increment  (increment),
    .sha_start  (sha_start),
    .sha_nonce  (sha_nonce),
    .sha_done   (sha_done),
    .sha_digest (sha_digest),
    .complete   (complete),
    .valid      (valid),
    .overflow   (overflow),
    .nonce      (nonce),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_attempt(input logic [DW-1:0] d, input logic exp_v, input bit load_in_cmp,
                             input string tag);
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    check({tag, "_start"}, sha_start, 1);
    check({tag, "_valid_clr"}, valid, 0);
    check({tag, "_timeout_clr"}, timeout, 0);
    tick();
    check({tag, "_start_1cyc"}, sha_start, 0);
    repeat (4) tick();
    sha_done = 1'b1; sha_digest = d; tick(); sha_done = 1'b0;
    check({tag, "_cmp_nocomplete"}, complete, 0);
    if (load_in_cmp) begin
      loadTarget = 1'b1; target_in = '0;
    end
    tick(); loadTarget = 1'b0;
    check({tag, "_complete"}, complete, 1);
    check({tag, "_valid"}, valid, exp_v);
    tick();
    check({tag, "_complete_1cyc"}, complete, 0);
    check({tag, "_valid_hold"}, valid, exp_v);
  endtask

  initial begin
    rst = 1'b1; loadTarget = 1'b0; target_in = '0; reset = 1'b0; beginSHA = 1'b0;
    increment = 1'b0; sha_done = 1'b0; sha_digest = '0;
    tgt = '0; tgt[240] = 1'b1;
    tick(); tick();
    check("rst_sha_start", sha_start, 0);
    check("rst_complete", complete, 0);
    check("rst_valid", valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_nonce", nonce, 0);
    check("rst_sha_nonce", sha_nonce, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0; tick();

    loadTarget = 1'b1; target_in = tgt; tick(); loadTarget = 1'b0;
    run_attempt(tgt >> 1, 1'b1, 1'b0, "below");
    run_attempt(tgt, 1'b0, 1'b0, "equal");
    run_attempt(tgt - 1, 1'b1, 1'b0, "minus1");
    // Load zero during CMP: compare must still use 2^240.
    run_attempt(tgt - 1, 1'b1, 1'b1, "cmp_load");
    run_attempt(tgt - 1, 1'b0, 1'b0, "new_target");
    loadTarget = 1'b1; target_in = tgt; tick(); loadTarget = 1'b0;

    // Nonce snapshot, ignored begin, soft abort.
    reset = 1'b1; tick(); reset = 1'b0;
    increment = 1'b1; repeat (7) tick(); increment = 1'b0;
    check("snap_nonce7", nonce, 7);
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    check("snap_sha_nonce", sha_nonce, 7);
    tick();
    increment = 1'b1; repeat (3) tick(); increment = 1'b0;
    check("snap_nonce10", nonce, 10);
    check("snap_sha_nonce_hold", sha_nonce, 7);
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    check("ignored_begin", sha_start, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_nonce", nonce, 0);
    check("abort_complete", complete, 0);
    sha_done = 1'b1; sha_digest = '0; tick(); sha_done = 1'b0;
    check("abort_done_a", complete, 0);
    tick(); check("abort_done_b", complete, 0);
    tick(); check("abort_done_c", complete, 0);
    run_attempt('0, 1'b1, 1'b0, "after_abort");

    // Soft reset beats increment.
    increment = 1'b1; repeat (5) tick();
    check("inc5", nonce, 5);
    reset = 1'b1; tick(); reset = 1'b0; increment = 1'b0;
    check("reset_wins", nonce, 0);

    // Wrap at all ones (8-bit nonce).
    increment = 1'b1; repeat (255) tick();
    check("wrap_ff", nonce, 8'hFF);
    check("wrap_noovf", overflow, 0);
    tick();
    check("wrap_zero", nonce, 0);
    check("wrap_ovf", overflow, 1);
    tick(); increment = 1'b0;
    check("wrap_one", nonce, 1);
    check("wrap_ovf_sticky", overflow, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("wrap_ovf_clr", overflow, 0);
    check("wrap_nonce_clr", nonce, 0);

`ifdef HASH_RESPONDER_WATCHDOG_EN
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    check("wd_start", sha_start, 1);
    repeat (16) tick();
    check("wd_wait16", complete, 0);
    tick();
    check("wd_complete", complete, 1);
    check("wd_timeout", timeout, 1);
    check("wd_valid", valid, 0);
    tick();
    check("wd_timeout_hold", timeout, 1);
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    check("wd_timeout_clr", timeout, 0);
    tick();
    sha_done = 1'b1; sha_digest = '0; tick(); sha_done = 1'b0;
    tick();
    check("wd_next_complete", complete, 1);
    check("wd_next_valid", valid, 1);
    tick();
`else
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    check("nowd_start", sha_start, 1);
    repeat (40) tick();
    check("nowd_still_waiting", complete, 0);
    check("nowd_timeout", timeout, 0);
    sha_done = 1'b1; sha_digest = '1; tick(); sha_done = 1'b0;
    tick();
    check("nowd_complete", complete, 1);
    check("nowd_valid", valid, 0);
    tick();
`endif

    // Hard reset mid-attempt: no completion, target cleared.
    beginSHA = 1'b1; tick(); beginSHA = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_complete", complete, 0);
    check("rst_mid_sha_nonce", sha_nonce, 0);
    check("rst_mid_valid", valid, 0);
    sha_done = 1'b1; sha_digest = '0; tick(); sha_done = 1'b0;
    check("rst_mid_done_a", complete, 0);
    tick(); check("rst_mid_done_b", complete, 0);
    tick(); check("rst_mid_done_c", complete, 0);
    run_attempt('0, 1'b0, 1'b0, "target_zero");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
